// File: rtl/box_drawer.sv
// box_drawer: erases the previously drawn box, then draws the new one, one pixel per clock.
// Pixels that fall off the visible screen are skipped but still cost a cycle.
`default_nettype none

module box_drawer #(
   parameter logic [8:0] BOX_WIDTH     = 9'd10,
   parameter logic [8:0] BOX_HEIGHT    = 9'd48,
   parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
   parameter logic [8:0] SCREEN_HEIGHT = 9'd240,
   parameter logic [2:0] BG_COLOR      = 3'b000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [8:0] in_x,
   input  logic [8:0] in_y,
   input  logic [2:0] in_color,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ERASE = 2'd1,
      S_DRAW  = 2'd2
   } state_t;

   state_t     state;
   logic [8:0] cx, cy;
   logic [8:0] old_x, old_y, new_x, new_y;
   logic [2:0] new_color;
   logic       have_old;

   logic       busy;
   logic       last_col, last_pix;
   logic [8:0] base_x, base_y;
   logic [9:0] px, py;
   logic       on_screen;

   assign last_col = (cx == BOX_WIDTH - 9'd1);
   assign last_pix = last_col && (cy == BOX_HEIGHT - 9'd1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cx        <= '0;
         cy        <= '0;
         old_x     <= '0;
         old_y     <= '0;
         new_x     <= '0;
         new_y     <= '0;
         new_color <= '0;
         have_old  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (s_valid) begin
                  new_x     <= in_x;
                  new_y     <= in_y;
                  new_color <= in_color;
                  cx        <= '0;
                  cy        <= '0;
                  state     <= have_old ? S_ERASE : S_DRAW;
               end
            end
            S_ERASE, S_DRAW: begin
               if (last_pix) begin
                  cx <= '0;
                  cy <= '0;
                  if (state == S_ERASE) begin
                     state <= S_DRAW;
                  end else begin
                     state    <= S_IDLE;
                     old_x    <= new_x;
                     old_y    <= new_y;
                     have_old <= 1'b1;
                  end
               end else if (last_col) begin
                  cx <= '0;
                  cy <= cy + 9'd1;
               end else begin
                  cx <= cx + 9'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; the extra bit keeps edge-of-screen sums from wrapping.
   assign busy      = (state == S_ERASE) || (state == S_DRAW);
   assign base_x    = (state == S_ERASE) ? old_x : new_x;
   assign base_y    = (state == S_ERASE) ? old_y : new_y;
   assign px        = {1'b0, base_x} + {1'b0, cx};
   assign py        = {1'b0, base_y} + {1'b0, cy};
   assign on_screen = (px < {1'b0, SCREEN_WIDTH}) && (py < {1'b0, SCREEN_HEIGHT});

   assign s_ready    = (state == S_IDLE);
   assign vga_plot   = busy && on_screen;
   assign vga_x      = busy ? px[8:0] : 9'd0;
   assign vga_y      = busy ? py[7:0] : 8'd0;
   assign vga_colour = (state == S_DRAW) ? new_color : BG_COLOR;

endmodule

`default_nettype wire
